mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Word-oriented memory bus between mem_access_unit and the
//               memory system. Single outstanding request, level-held
//               until acknowledged.
// Ports       : bus_req   - access in progress (master -> slave)
//               bus_we    - 1 = store, 0 = load
//               bus_addr  - word-aligned byte address, [1:0] always 00
//               bus_be    - byte lane enables
//               bus_wdata - lane-replicated store data
//               bus_ack   - one-cycle completion from the slave
//               bus_rdata - raw 32-bit read word, valid with bus_ack
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store unit between the pipeline and a word bus. Accepts
//               one byte/half/word access in IDLE, runs it on the bus with a
//               timeout, lane-extracts and sign/zero-extends load data and
//               pulses done for one cycle.
// Parameters  : TIMEOUT_CYCLES - BUSY cycles without ack before abort (1..255)
// Ports       : clk, reset            - clock, synchronous active-high reset
//               mem_read, mem_write   - access request (write wins if both)
//               inst_size             - 00 byte, 01 half, 1x word
//               load_unsigned         - zero-extend instead of sign-extend
//               addr, wdata           - byte address and store data
//               rdata_out             - last completed load value
//               done                  - one-cycle completion pulse
//               stall                 - pipeline hold while access pending
//               misalign, bus_err     - status, valid with done
//               bus                   - memory bus (master modport)
// Options     : MEM_ACCESS_MISALIGN_CHECK_EN - when defined, misaligned half
//               and word accesses complete immediately with misalign=1 and
//               never reach the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        mem_read,
    input  wire logic        mem_write,
    input  wire logic [1:0]  inst_size,
    input  wire logic        load_unsigned,
    input  wire logic [31:0] addr,
    input  wire logic [31:0] wdata,
    output logic      [31:0] rdata_out,
    output logic             done,
    output logic             stall,
    output logic             misalign,
    output logic             bus_err,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_we;
    logic [7:0]  r_cnt;
    logic        r_misalign;
    logic        r_bus_err;

    logic        w_req;
    logic        w_misaligned;
    logic        w_cnt_last;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_req = mem_read | mem_write;

    // The counter holds the number of ack-less BUSY cycles already elapsed,
    // so the current cycle is the last allowed one when count+1 hits the limit.
    assign w_cnt_last = ((r_cnt + 8'd1) == C_TIMEOUT);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    // Judged on the live inputs: the decision is needed on the accept edge.
    always_comb begin
        case (inst_size)
            SZ_BYTE: w_misaligned = 1'b0;
            SZ_HALF: w_misaligned = addr[0];
            default: w_misaligned = (addr[1:0] != 2'b00);
        endcase
    end
`else
    assign w_misaligned = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Store lane steering (also drives byte enables for loads)
    // ------------------------------------------------------------------------
    always_comb begin
        case (r_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------------
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = bus.bus_rdata[7:0];
            2'd1:    w_byte = bus.bus_rdata[15:8];
            2'd2:    w_byte = bus.bus_rdata[23:16];
            default: w_byte = bus.bus_rdata[31:24];
        endcase
        w_half = r_addr[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (r_size)
            SZ_BYTE: w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load_data = bus.bus_rdata;
        endcase
    end

    // Address and data are held from the registered request, so they stay
    // stable for the whole BUSY phase; only req/we/be are phase-gated.
    assign bus.bus_addr  = {r_addr[31:2], 2'b00};
    assign bus.bus_wdata = w_wdata;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        stall       = 1'b0;
        done        = 1'b0;
        bus.bus_req = 1'b0;
        bus.bus_we  = 1'b0;
        bus.bus_be  = 4'b0000;
        case (r_state)
            IDLE: begin
                stall = w_req;
                if (w_req) begin
                    w_next = w_misaligned ? RESP : BUSY;
                end
            end
            BUSY: begin
                stall       = 1'b1;
                bus.bus_req = 1'b1;
                bus.bus_we  = r_we;
                bus.bus_be  = w_be;
                // Ack takes priority over an expiring timeout.
                if (bus.bus_ack || w_cnt_last) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign misalign = done & r_misalign;
    assign bus_err  = done & r_bus_err;

    // ------------------------------------------------------------------------
    // Request capture, timeout counter and load result
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_cnt      <= 8'd0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            rdata_out  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr     <= addr;
                        r_wdata    <= wdata;
                        r_size     <= inst_size;
                        r_unsigned <= load_unsigned;
                        r_we       <= mem_write;
                        r_cnt      <= 8'd0;
                        r_misalign <= w_misaligned;
                        r_bus_err  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (bus.bus_ack) begin
                        if (!r_we) begin
                            rdata_out <= w_load_data;
                        end
                    end else if (w_cnt_last) begin
                        r_bus_err <= 1'b1;
                        // A failed load reports zero; a failed store leaves
                        // the last load value untouched.
                        if (!r_we) begin
                            rdata_out <= 32'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Randomized scoreboard bench for mem_access_unit. A driver
//               issues accesses and pushes expected bus transactions and
//               responses; a bus-slave process and a response monitor pop
//               and compare independently.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, load_unsigned;
    logic [1:0]  inst_size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_out;
    logic        done, stall, misalign, bus_err;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .inst_size     (inst_size),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .rdata_out     (rdata_out),
        .done          (done),
        .stall         (stall),
        .misalign      (misalign),
        .bus_err       (bus_err),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        bit          mis;
        bit          err;
        int          cyc;
    } resp_exp_t;

    bus_exp_t    bus_q[$];
    resp_exp_t   resp_q[$];
    logic [31:0] model_rdata = 32'd0;
    bit          mon_en = 1'b0;
    bit          flush  = 1'b0;
    int          tests  = 0;
    int          fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a % 4);
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit uns,
                                             input logic [31:0] a, input logic [31:0] rd);
        int unsigned v, bits, shift;
        if (sz >= 2'd2) return rd;
        bits  = (sz == 2'd0) ? 8 : 16;
        shift = (sz == 2'd0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
        v = (rd >> shift) & ((32'd1 << bits) - 1);
        if (!uns && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic do_access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int delay, input logic [31:0] brd);
        bus_exp_t  b;
        resp_exp_t r;
        bit        mis;
        int        n;
        bit        got;
        @(negedge clk);
        mem_read = rd; mem_write = wr; inst_size = sz; load_unsigned = uns;
        addr = a; wdata = wd;
        mis = is_mis(sz, a);
        r.mis = mis;
        r.err = 1'b0;
        if (mis) begin
            r.cyc = cyc + 1;
        end else begin
            b.we = wr; b.addr = a & ~32'd3; b.be = exp_be(sz, a);
            b.wdata = exp_wdata(sz, wd); b.delay = delay; b.rdata = brd;
            bus_q.push_back(b);
            if (delay < TO) begin
                r.cyc = cyc + delay + 2;
                if (!wr) model_rdata = exp_load(sz, uns, a, brd);
            end else begin
                r.cyc = cyc + TO + 1;
                r.err = 1'b1;
                if (!wr) model_rdata = 32'd0;
            end
        end
        r.rdata = model_rdata;
        resp_q.push_back(r);
        #1;
        check("stall_on_request", {31'd0, stall}, 32'd1);
        // Scramble request inputs while the access is in flight; they must be ignored.
        n = 0; got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            mem_read = 1'($urandom); mem_write = 1'($urandom);
            addr = $urandom; wdata = $urandom;
            inst_size = 2'($urandom); load_unsigned = 1'($urandom);
            #1;
            got = (resp_q.size() == 0);
            n++;
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            resp_q.delete();
            bus_q.delete();
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // ---------------- bus slave ----------------
    initial begin
        bit       active = 1'b0;
        int       w = 0;
        bus_exp_t cur;
        bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (flush) begin active = 1'b0; flush = 1'b0; end
            // Spurious acks while not in a transaction must be ignored.
            bus.bus_ack   = ($urandom % 4) == 0;
            bus.bus_rdata = $urandom;
            if (mon_en && bus.bus_req === 1'b1) begin
                if (!active) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_bus_req", 32'd1, 32'd0);
                    end else begin
                        cur = bus_q.pop_front(); active = 1'b1; w = 0;
                    end
                end
                if (active) begin
                    check("bus_we", {31'd0, bus.bus_we}, {31'd0, cur.we});
                    check("bus_addr", bus.bus_addr, cur.addr);
                    check("bus_be", {28'd0, bus.bus_be}, {28'd0, cur.be});
                    if (cur.we) check("bus_wdata", bus.bus_wdata, cur.wdata);
                    if (w == cur.delay) begin
                        bus.bus_ack = 1'b1; bus.bus_rdata = cur.rdata; active = 1'b0;
                    end else begin
                        bus.bus_ack = 1'b0;
                    end
                    w++;
                end
            end else if (active) begin
                check("bus_req_cycles_before_timeout", w, TO);
                active = 1'b0;
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        resp_exp_t r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (done === 1'b1) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        r = resp_q.pop_front();
                        check("rdata_out", rdata_out, r.rdata);
                        check("misalign", {31'd0, misalign}, {31'd0, r.mis});
                        check("bus_err", {31'd0, bus_err}, {31'd0, r.err});
                        check("done_cycle", cyc, r.cyc);
                        check("stall_in_resp", {31'd0, stall}, 32'd0);
                    end
                end else if (misalign !== 1'b0 || bus_err !== 1'b0) begin
                    check("status_without_done", {30'd0, misalign, bus_err}, 32'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus_exp_t b;
        bit rd, wr;
        int d;
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; inst_size = 2'd0;
        load_unsigned = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdata_out", rdata_out, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
        check("rst_bus_we", {31'd0, bus.bus_we}, 32'd0);
        check("rst_bus_be", {28'd0, bus.bus_be}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Directed cases
        do_access(1, 0, 2'd2, 0, 32'h104, 32'h0, 0, 32'hDEADBEEF);
        do_access(1, 0, 2'd0, 0, 32'h103, 32'h0, 1, 32'h80112233);
        do_access(1, 0, 2'd0, 1, 32'h103, 32'h0, 2, 32'h80112233);
        do_access(0, 1, 2'd1, 0, 32'h202, 32'h0000ABCD, 0, 32'h0);
        do_access(1, 0, 2'd2, 0, 32'h108, 32'h0, 99, 32'h0);        // load timeout
        do_access(1, 0, 2'd1, 0, 32'h106, 32'h0, 3, 32'h8001_7FFF);  // ack on last allowed cycle
        do_access(0, 1, 2'd2, 0, 32'h10C, 32'h12345678, 99, 32'h0);  // store timeout
        do_access(1, 1, 2'd0, 0, 32'h301, 32'hA5A5_A5C3, 0, 32'h0);  // both high -> write
        do_access(1, 0, 2'd2, 0, 32'h101, 32'h0, 0, 32'hCAFEF00D);   // misaligned word
        do_access(1, 0, 2'd1, 0, 32'h105, 32'h0, 0, 32'h1234F00D);   // misaligned half

        // Reset in the middle of a BUSY wait
        @(negedge clk);
        mem_read = 1'b1; inst_size = 2'd2; addr = 32'h400;
        b.we = 1'b0; b.addr = 32'h400; b.be = 4'hF; b.wdata = 32'h0; b.delay = 99; b.rdata = 32'h0;
        bus_q.push_back(b);
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #2 flush = 1'b1; bus_q.delete();
        @(negedge clk);
        #1;
        check("abort_bus_req", {31'd0, bus.bus_req}, 32'd0);
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_rdata_out", rdata_out, 32'd0);
        reset = 1'b0;
        model_rdata = 32'd0;
        do_access(0, 1, 2'd2, 0, 32'h500, 32'h0BAD_F00D, 1, 32'h0);
        do_access(1, 0, 2'd1, 1, 32'h502, 32'h0, 0, 32'hFEDC_8765);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            d = ($urandom % 8 == 0) ? int'($urandom_range(TO, TO + 2)) : int'($urandom_range(0, TO - 1));
            do_access(rd, wr, 2'($urandom), 1'($urandom), $urandom, $urandom, d, $urandom);
        end

        repeat (5) @(negedge clk);
        check("resp_queue_drained", resp_q.size(), 32'd0);
        check("bus_queue_drained", bus_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
